// File: rtl/dmi_txn_handler.sv
// DMI transaction engine: one request word in, one debug-module bus access, one response word out.
// Optional access timeout (BUSY response plus orphaned-completion tracking) enabled by DMI_TXN_TIMEOUT_EN.
module dmi_txn_handler #(
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ADDR_W+DATA_W+1:0] req_data_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  output logic [DATA_W+1:0]        resp_data_o,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic                     dm_req_o,
  output logic                     dm_we_o,
  output logic [ADDR_W-1:0]        dm_addr_o,
  output logic [DATA_W-1:0]        dm_wdata_o,
  input  logic                     dm_gnt_i,
  input  logic                     dm_rvalid_i,
  input  logic [DATA_W-1:0]        dm_rdata_i,
  input  logic                     dm_err_i,
  output logic                     busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RV, RESP} state_e;

  localparam logic [1:0] OP_NOP     = 2'd0;
  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_WRITE   = 2'd2;
  localparam logic [1:0] RSP_OK     = 2'd0;
  localparam logic [1:0] RSP_FAILED = 2'd2;
  localparam logic [1:0] RSP_BUSY   = 2'd3;

  generate
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("dmi_txn_handler: TIMEOUT_CYCLES must be >= 2");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [1:0]          op_q;
  logic [DATA_W+1:0]   resp_q;
  logic                orphan;
  logic                timeout_hit;
  logic                accept;
  logic [1:0]          req_op;
  logic [DATA_W-1:0]   req_wdata;
  logic [ADDR_W-1:0]   req_addr;

  assign req_op    = req_data_i[1:0];
  assign req_wdata = req_data_i[DATA_W+1:2];
  assign req_addr  = req_data_i[ADDR_W+DATA_W+1:DATA_W+2];
  assign accept    = (state_q == IDLE) && req_valid_i && !orphan;

`ifdef DMI_TXN_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] cnt_q;
  logic             orphan_q;

  assign orphan      = orphan_q;
  assign timeout_hit = ((state_q == ISSUE) || (state_q == WAIT_RV)) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if ((state_q == IDLE) && (state_d == ISSUE)) begin
      cnt_q <= '0;
    end else if ((state_q == ISSUE) || (state_q == WAIT_RV)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A grant seen on the expiry cycle also leaves a completion owed by the bus.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      orphan_q <= 1'b0;
    end else if (orphan_q && dm_rvalid_i) begin
      orphan_q <= 1'b0;
    end else if (timeout_hit && (((state_q == WAIT_RV) && !dm_rvalid_i) ||
                                 ((state_q == ISSUE) && dm_gnt_i))) begin
      orphan_q <= 1'b1;
    end
  end
`else
  assign orphan      = 1'b0;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((req_op == OP_READ) || (req_op == OP_WRITE)) state_d = ISSUE;
          else                                             state_d = RESP;
        end
      end
      ISSUE: begin
        if (timeout_hit)   state_d = RESP;
        else if (dm_gnt_i) state_d = WAIT_RV;
      end
      WAIT_RV: begin
        if (dm_rvalid_i || timeout_hit) state_d = RESP;
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == IDLE) && !orphan;
    resp_valid_o = (state_q == RESP);
    busy_o       = (state_q != IDLE) || orphan;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dm_req_o   <= 1'b0;
      dm_we_o    <= 1'b0;
      dm_addr_o  <= '0;
      dm_wdata_o <= '0;
      op_q       <= OP_NOP;
    end else begin
      dm_req_o <= (state_d == ISSUE);
      if (accept) begin
        dm_addr_o  <= req_addr;
        dm_wdata_o <= req_wdata;
        dm_we_o    <= (req_op == OP_WRITE);
        op_q       <= req_op;
      end
    end
  end

  // Completion takes priority over a timeout expiring in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q <= '0;
    end else if (accept && (req_op == OP_NOP)) begin
      resp_q <= {{DATA_W{1'b0}}, RSP_OK};
    end else if (accept && (req_op != OP_READ) && (req_op != OP_WRITE)) begin
      resp_q <= {{DATA_W{1'b0}}, RSP_FAILED};
    end else if ((state_q == WAIT_RV) && dm_rvalid_i) begin
      resp_q <= {(op_q == OP_READ) ? dm_rdata_i : {DATA_W{1'b0}},
                 dm_err_i ? RSP_FAILED : RSP_OK};
    end else if (timeout_hit) begin
      resp_q <= {{DATA_W{1'b0}}, RSP_BUSY};
    end
  end

  assign resp_data_o = resp_q;

endmodule

// File: tb/tb_dmi_txn_handler.sv
// Self-checking bench for dmi_txn_handler: directed scenarios plus randomized transactions vs a reference model.
// Timeout scenarios run only when DMI_TXN_TIMEOUT_EN is defined.
module tb_dmi_txn_handler;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [40:0] req_data_i = '0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [33:0] resp_data_o;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [6:0]  dm_addr_o;
  logic [31:0] dm_wdata_o;
  logic        dm_gnt_i = 1'b0;
  logic        dm_rvalid_i = 1'b0;
  logic [31:0] dm_rdata_i = '0;
  logic        dm_err_i = 1'b0;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  dmi_txn_handler #(.ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .resp_data_o(resp_data_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o),
    .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i), .dm_err_i(dm_err_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected response word from the op/resp encoding rules.
  function automatic logic [33:0] model(input logic [1:0] op, input logic [31:0] rdata, input logic err);
    logic [1:0] code;
    code = err ? 2'd2 : 2'd0;
    case (op)
      2'd0:    return 34'h0;
      2'd1:    return {rdata, code};
      2'd2:    return {32'h0, code};
      default: return {32'h0, 2'd2};
    endcase
  endfunction

  task automatic do_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                        input int g, input int r, input logic [31:0] rdata, input logic err, input int rr);
    logic [33:0] exp;
    int n;
    exp = model(op, rdata, err);
    n = 0;
    while (!req_ready_o && n < 20) begin @(posedge clk_i); #1; n++; end
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL ready_wait: req_ready_o=%b required 1", req_ready_o); end
    req_data_i = {addr, wdata, op};
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    if (op == 2'd1 || op == 2'd2) begin
      for (int i = 0; i <= g; i++) begin
        checks++;
        if ({dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o, resp_valid_o, req_ready_o, busy_o} !==
            {1'b1, (op == 2'd2), addr, wdata, 1'b0, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL issue_payload cyc%0d: req=%b we=%b addr=%h wdata=%h rv=%b rdy=%b busy=%b required req=1 we=%b addr=%h wdata=%h rv=0 rdy=0 busy=1",
                   i, dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o, resp_valid_o, req_ready_o, busy_o, (op == 2'd2), addr, wdata);
        end
        if (i == g) dm_gnt_i = 1'b1;
        @(posedge clk_i); #1;
      end
      dm_gnt_i = 1'b0;
      for (int i = 0; i <= r; i++) begin
        checks++;
        if ({dm_req_o, resp_valid_o, busy_o} !== 3'b001) begin
          errors++;
          $display("FAIL wait_rv cyc%0d: req=%b rv=%b busy=%b required 0 0 1", i, dm_req_o, resp_valid_o, busy_o);
        end
        if (i == r) begin dm_rvalid_i = 1'b1; dm_rdata_i = rdata; dm_err_i = err; end
        @(posedge clk_i); #1;
      end
      dm_rvalid_i = 1'b0;
      dm_rdata_i = $urandom;
      dm_err_i = 1'b0;
    end
    for (int i = 0; i <= rr; i++) begin
      checks++;
      if ({resp_valid_o, resp_data_o, req_ready_o} !== {1'b1, exp, 1'b0}) begin
        errors++;
        $display("FAIL resp cyc%0d: valid=%b data=%h ready=%b required valid=1 data=%h ready=0",
                 i, resp_valid_o, resp_data_o, req_ready_o, exp);
      end
      if (i == rr) resp_ready_i = 1'b1;
      @(posedge clk_i); #1;
    end
    resp_ready_i = 1'b0;
    checks++;
    if ({resp_valid_o, req_ready_o, busy_o, dm_req_o} !== 4'b0100) begin
      errors++;
      $display("FAIL after_resp: rv=%b rdy=%b busy=%b req=%b required 0 1 0 0", resp_valid_o, req_ready_o, busy_o, dm_req_o);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({req_ready_o, resp_valid_o, dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o, resp_data_o, busy_o} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0, 34'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: rdy=%b rv=%b req=%b we=%b addr=%h wdata=%h resp=%h busy=%b required 1 0 0 0 0 0 0 0",
               req_ready_o, resp_valid_o, dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o, resp_data_o, busy_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_read();
    do_txn(2'd1, 7'h11, 32'h1234_5678, 0, 0, 32'hDEAD_BEEF, 1'b0, 0);
  endtask

  task automatic test_write_stall();
    do_txn(2'd2, 7'h10, 32'h0000_0001, 5, 0, 32'hFFFF_FFFF, 1'b1, 0);
  endtask

  task automatic test_nop_reserved();
    do_txn(2'd0, 7'h33, 32'hA5A5_A5A5, 0, 0, 32'h0, 1'b0, 4);
    do_txn(2'd3, 7'h44, 32'h5A5A_5A5A, 0, 0, 32'h0, 1'b0, 4);
  endtask

  task automatic test_back_to_back();
    req_data_i = {7'h00, 32'h0, 2'd0};
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_data_i = {7'h22, 32'h5, 2'd3};
    resp_ready_i = 1'b1;
    checks++;
    if ({resp_valid_o, req_ready_o, resp_data_o} !== {1'b1, 1'b0, 34'h0}) begin
      errors++;
      $display("FAIL b2b_first: rv=%b rdy=%b data=%h required 1 0 0", resp_valid_o, req_ready_o, resp_data_o);
    end
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    checks++;
    if ({resp_valid_o, req_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_gap: rv=%b rdy=%b required 0 1", resp_valid_o, req_ready_o);
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    checks++;
    if ({resp_valid_o, resp_data_o, dm_req_o, dm_addr_o} !== {1'b1, 34'h2, 1'b0, 7'h22}) begin
      errors++;
      $display("FAIL b2b_second: rv=%b data=%h req=%b addr=%h required 1 2 0 22", resp_valid_o, resp_data_o, dm_req_o, dm_addr_o);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    checks++;
    if ({resp_valid_o, req_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_done: rv=%b rdy=%b required 0 1", resp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_mid_reset();
    req_data_i = {7'h05, 32'h0, 2'd1};
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    dm_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    dm_gnt_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy: busy=%b required 1", busy_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, resp_valid_o, dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o, resp_data_o, busy_o} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0, 34'h0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_values: rdy=%b rv=%b req=%b we=%b addr=%h wdata=%h resp=%h busy=%b required 1 0 0 0 0 0 0 0",
               req_ready_o, resp_valid_o, dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o, resp_data_o, busy_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    dm_rvalid_i = 1'b1;
    dm_rdata_i = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      dm_rvalid_i = 1'b0;
      checks++;
      if ({resp_valid_o, req_ready_o, busy_o} !== 3'b010) begin
        errors++;
        $display("FAIL stale_resp cyc%0d: rv=%b rdy=%b busy=%b required 0 1 0", i, resp_valid_o, req_ready_o, busy_o);
      end
    end
    do_txn(2'd1, 7'h05, 32'h0, 1, 1, 32'hC0FF_EE00, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      do_txn(2'($urandom_range(0, 3)), 7'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom, 1'($urandom), $urandom_range(0, 2));
    end
  endtask

`ifdef DMI_TXN_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    logic [31:0] rd;
    req_data_i = {7'h12, 32'h0, 2'd1};
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    dm_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    dm_gnt_i = 1'b0;
    k = 2;
    while (!resp_valid_o && k < 40) begin @(posedge clk_i); #1; k++; end
    checks++;
    if ({k, resp_data_o} !== {32'd9, 34'h3}) begin
      errors++;
      $display("FAIL timeout_resp: cycle=%0d data=%h required cycle=9 data=3", k, resp_data_o);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({req_ready_o, busy_o, resp_valid_o, dm_req_o} !== 4'b0100) begin
        errors++;
        $display("FAIL orphan_hold cyc%0d: rdy=%b busy=%b rv=%b req=%b required 0 1 0 0", i, req_ready_o, busy_o, resp_valid_o, dm_req_o);
      end
      @(posedge clk_i); #1;
    end
    dm_rvalid_i = 1'b1;
    dm_rdata_i = 32'h7777_7777;
    @(posedge clk_i); #1;
    dm_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({req_ready_o, busy_o, resp_valid_o} !== 3'b100) begin
        errors++;
        $display("FAIL orphan_clear cyc%0d: rdy=%b busy=%b rv=%b required 1 0 0", i, req_ready_o, busy_o, resp_valid_o);
      end
      @(posedge clk_i); #1;
    end
    rd = $urandom;
    req_data_i = {7'h13, 32'h0, 2'd1};
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    dm_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    dm_gnt_i = 1'b0;
    for (k = 2; k < 8; k++) begin @(posedge clk_i); #1; end
    dm_rvalid_i = 1'b1;
    dm_rdata_i = rd;
    @(posedge clk_i); #1;
    dm_rvalid_i = 1'b0;
    checks++;
    if ({resp_valid_o, resp_data_o} !== {1'b1, rd, 2'b00}) begin
      errors++;
      $display("FAIL expiry_race: rv=%b data=%h required 1 %h", resp_valid_o, resp_data_o, {rd, 2'b00});
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    checks++;
    if ({req_ready_o, busy_o} !== 2'b10) begin
      errors++;
      $display("FAIL expiry_no_orphan: rdy=%b busy=%b required 1 0", req_ready_o, busy_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_nop_reserved();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef DMI_TXN_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
